// File: rtl/ppu_pkg.sv
// Shared timing constants, palette indices and pattern selection for the stand-in PPU pixel source.
package ppu_pkg;

    localparam logic [9:0] DOTS_PER_LINE   = 10'd341;
    localparam logic [9:0] LINES_PER_FRAME = 10'd262;
    localparam logic [9:0] VISIBLE_W       = 10'd256;
    localparam logic [9:0] VISIBLE_H       = 10'd240;
    localparam logic [9:0] VBLANK_SET_LINE = 10'd241;
    localparam logic [9:0] PRERENDER_LINE  = LINES_PER_FRAME - 10'd1;

    localparam logic [5:0] PAL_BLACK = 6'h0F;
    localparam logic [5:0] PAL_WHITE = 6'h30;
    localparam logic [5:0] PAL_GRID  = 6'h20;

    typedef enum logic [2:0] {
        PAT_SOLID = 3'd0,
        PAT_VBARS = 3'd1,
        PAT_HBARS = 3'd2,
        PAT_CHECK = 3'd3,
        PAT_GRAD  = 3'd4,
        PAT_GRID  = 3'd5
    } pattern_e;

    // Codes 5..7 all select the grid so every switch setting shows something.
    function automatic logic [5:0] pattern_index(input logic [2:0] sel,
                                                 input logic [7:0] xe,
                                                 input logic [7:0] y,
                                                 input logic [5:0] solid);
        logic [5:0] diag;
        diag = xe[5:0] + y[5:0];
        case (sel)
            PAT_SOLID: return solid;
            PAT_VBARS: return {1'b0, xe[7:3]};
            PAT_HBARS: return {1'b0, y[7:3]};
            PAT_CHECK: return (xe[3] ^ y[3]) ? PAL_WHITE : PAL_BLACK;
            PAT_GRAD:  return diag;
            default:   return ((xe[2:0] == 3'd0) || (y[2:0] == 3'd0)) ? PAL_GRID : PAL_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/ppu_pattern_gen_if.sv
// Pixel bus from the PPU pixel source to the scan converter; master drives, slave consumes.
interface ppu_pattern_gen_if;

    logic [7:0] ppu_pixel;
    logic [9:0] ppu_x;
    logic [9:0] ppu_y;
    logic       pixel_valid;
    logic       vblank;
    logic       frame_start;

    modport master (
        output ppu_pixel, ppu_x, ppu_y, pixel_valid, vblank, frame_start
    );

    modport slave (
        input ppu_pixel, ppu_x, ppu_y, pixel_valid, vblank, frame_start
    );

endinterface

// File: rtl/button_sync_edge.sv
// Two-flop synchronizer for an asynchronous push-button followed by a one-cycle rising-edge pulse.
module button_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic pulse_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= btn_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign pulse_o = sync_q & ~prev_q;

endmodule

// File: rtl/ppu_pattern_gen.sv
// NES-timed test pattern pixel source feeding the VGA/HDMI path in place of the real PPU.
// Optional feature: define PPU_ODD_FRAME_SKIP_EN to drop dot 340 of the pre-render line on odd frames.
module ppu_pattern_gen
    import ppu_pkg::*;
(
    input  logic        ppu_clk,
    input  logic        reset,
    input  logic [15:0] SW,
    input  logic        Run,
    output logic [7:0]  ppu_pixel,
    output logic [9:0]  ppu_x,
    output logic [9:0]  ppu_y,
    output logic        pixel_valid,
    output logic        vblank,
    output logic        frame_start
);

    logic [9:0] dot_q, dot_d;
    logic [9:0] line_q, line_d;
    logic [7:0] scroll_q, scroll_d;
    logic       frame_odd_q, frame_odd_d;
    logic       vblank_q, vblank_d;
    logic [7:0] pixel_q, pixel_d;
    logic [9:0] x_q, y_q;
    logic       valid_q, valid_d;
    logic       fstart_q, fstart_d;

    logic [9:0] last_dot;
    logic       line_end;
    logic       frame_wrap;
    logic       run_pulse;
    logic       scroll_inc;
    logic [7:0] xe;
    logic       unused_sw;

    assign unused_sw = ^{SW[7:3], SW[14]};

    button_sync_edge u_run_sync (
        .clk     (ppu_clk),
        .reset   (reset),
        .btn_i   (Run),
        .pulse_o (run_pulse)
    );

    // Outputs are computed from the current counter state so they trail it by exactly one clock.
    always_comb begin
        last_dot = DOTS_PER_LINE - 10'd1;
`ifdef PPU_ODD_FRAME_SKIP_EN
        if (frame_odd_q && (line_q == PRERENDER_LINE)) begin
            last_dot = DOTS_PER_LINE - 10'd2;
        end
`endif
        line_end   = (dot_q == last_dot);
        frame_wrap = line_end && (line_q == PRERENDER_LINE);

        dot_d = line_end ? 10'd0 : dot_q + 10'd1;
        if (frame_wrap) begin
            line_d = 10'd0;
        end else if (line_end) begin
            line_d = line_q + 10'd1;
        end else begin
            line_d = line_q;
        end
        frame_odd_d = frame_odd_q ^ frame_wrap;

        // In step mode only the button moves the scroll, so a press landing on a frame wrap counts once.
        scroll_inc = SW[15] ? frame_wrap : run_pulse;
        scroll_d   = scroll_q + {7'd0, scroll_inc};

        valid_d = (dot_q < VISIBLE_W) && (line_q < VISIBLE_H);
        xe      = dot_q[7:0] + scroll_q;
        pixel_d = {2'b00, valid_d ? pattern_index(SW[2:0], xe, line_q[7:0], SW[13:8]) : PAL_BLACK};

        vblank_d = vblank_q;
        if ((dot_q == 10'd1) && (line_q == VBLANK_SET_LINE)) begin
            vblank_d = 1'b1;
        end else if ((dot_q == 10'd1) && (line_q == PRERENDER_LINE)) begin
            vblank_d = 1'b0;
        end

        fstart_d = (dot_q == 10'd0) && (line_q == 10'd0);
    end

    always_ff @(posedge ppu_clk) begin
        if (reset) begin
            dot_q       <= 10'd0;
            line_q      <= 10'd0;
            scroll_q    <= 8'd0;
            frame_odd_q <= 1'b0;
            vblank_q    <= 1'b0;
            pixel_q     <= {2'b00, PAL_BLACK};
            x_q         <= 10'd0;
            y_q         <= 10'd0;
            valid_q     <= 1'b0;
            fstart_q    <= 1'b0;
        end else begin
            dot_q       <= dot_d;
            line_q      <= line_d;
            scroll_q    <= scroll_d;
            frame_odd_q <= frame_odd_d;
            vblank_q    <= vblank_d;
            pixel_q     <= pixel_d;
            x_q         <= dot_q;
            y_q         <= line_q;
            valid_q     <= valid_d;
            fstart_q    <= fstart_d;
        end
    end

    assign ppu_pixel   = pixel_q;
    assign ppu_x       = x_q;
    assign ppu_y       = y_q;
    assign pixel_valid = valid_q;
    assign vblank      = vblank_q;
    assign frame_start = fstart_q;

endmodule

// File: tb/tb_ppu_pattern_gen.sv
// Randomized scoreboard bench for ppu_pattern_gen against a frame-position reference model.
module tb_ppu_pattern_gen;

    localparam int DOTS  = 341;
    localparam int LINES = 262;

    typedef struct {
        logic [7:0] pix;
        logic [9:0] x;
        logic [9:0] y;
        logic       valid;
        logic       vb;
        logic       fs;
    } exp_t;

    logic        ppu_clk = 1'b0;
    logic        reset   = 1'b1;
    logic        Run     = 1'b0;
    logic [15:0] SW      = 16'h0000;

    ppu_pattern_gen_if pif ();

    ppu_pattern_gen dut (
        .ppu_clk     (ppu_clk),
        .reset       (reset),
        .SW          (SW),
        .Run         (Run),
        .ppu_pixel   (pif.ppu_pixel),
        .ppu_x       (pif.ppu_x),
        .ppu_y       (pif.ppu_y),
        .pixel_valid (pif.pixel_valid),
        .vblank      (pif.vblank),
        .frame_start (pif.frame_start)
    );

    always #5 ppu_clk = ~ppu_clk;

    exp_t expQ[$];
    int   checks = 0;
    int   passes = 0;
    int   cycle  = 0;

    // Reference state: position inside the current frame, scroll, and Run as seen at recent edges.
    int   frameIdx = 0;
    int   frameOff = 0;
    int   scroll   = 0;
    bit   s1 = 0, s2 = 0, s3 = 0;

    function automatic int frameLen(input int f);
`ifdef PPU_ODD_FRAME_SKIP_EN
        return ((f % 2) == 1) ? DOTS * LINES - 1 : DOTS * LINES;
`else
        return (f >= 0) ? DOTS * LINES : 0;
`endif
    endfunction

    function automatic logic [5:0] refPattern(input int sel, input int xe, input int y, input int solid);
        int v;
        case (sel)
            0:       v = solid;
            1:       v = xe / 8;
            2:       v = y / 8;
            3:       v = (((xe / 8) % 2) != ((y / 8) % 2)) ? 'h30 : 'h0F;
            4:       v = (xe + y) % 64;
            default: v = (((xe % 8) == 0) || ((y % 8) == 0)) ? 'h20 : 'h0F;
        endcase
        return 6'(v);
    endfunction

    // Drive one clock's inputs and queue the output the DUT must show after the coming edge.
    task automatic applyStimulus(input logic rstIn, input logic [15:0] swIn, input logic runIn);
        exp_t e;
        int   line;
        int   dot;
        int   xe;
        bit   last;
        bit   pulse;
        @(negedge ppu_clk);
        reset = rstIn;
        SW    = swIn;
        Run   = runIn;
        if (rstIn) begin
            e = '{8'h0F, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0};
            frameIdx = 0;
            frameOff = 0;
            scroll   = 0;
            s1 = 0;
            s2 = 0;
            s3 = 0;
        end else begin
            line    = frameOff / DOTS;
            dot     = frameOff % DOTS;
            e.x     = 10'(dot);
            e.y     = 10'(line);
            e.valid = (dot < 256) && (line < 240);
            xe      = (dot + scroll) % 256;
            e.pix   = e.valid ? {2'b00, refPattern(int'(swIn[2:0]), xe, line, int'(swIn[13:8]))} : 8'h0F;
            e.vb    = (frameOff >= 241 * DOTS + 1) && (frameOff < 261 * DOTS + 1);
            e.fs    = (frameOff == 0);
            last    = (frameOff == frameLen(frameIdx) - 1);
            pulse   = s2 && !s3;
            if (swIn[15] ? last : pulse) scroll = (scroll + 1) % 256;
            s3 = s2;
            s2 = s1;
            s1 = runIn;
            frameOff++;
            if (frameOff == frameLen(frameIdx)) begin
                frameOff = 0;
                frameIdx++;
            end
        end
        expQ.push_back(e);
    endtask

    task automatic checkOutput(input exp_t e);
        checks++;
        if (pif.ppu_pixel === e.pix && pif.ppu_x === e.x && pif.ppu_y === e.y &&
            pif.pixel_valid === e.valid && pif.vblank === e.vb && pif.frame_start === e.fs) begin
            passes++;
        end else begin
            $display("[TB] FAIL outputs cycle %0d: got pix=%h x=%0d y=%0d valid=%b vblank=%b fs=%b, want pix=%h x=%0d y=%0d valid=%b vblank=%b fs=%b",
                     cycle, pif.ppu_pixel, pif.ppu_x, pif.ppu_y, pif.pixel_valid, pif.vblank, pif.frame_start,
                     e.pix, e.x, e.y, e.valid, e.vb, e.fs);
        end
    endtask

    // Monitor: the DUT presents a new pixel every clock, so compare one queued entry per edge.
    initial begin
        forever begin
            @(posedge ppu_clk);
            #1;
            cycle++;
            if (expQ.size() > 0) checkOutput(expQ.pop_front());
        end
    end

    logic [15:0] swCur  = 16'h0000;
    logic        runCur = 1'b0;
    int          swHold = 0;
    int          runHold = 0;

    task automatic randomStep(input bit forceFreeRun);
        if (swHold == 0) begin
            swCur  = 16'($urandom);
            swHold = $urandom_range(1, 300);
        end
        swHold--;
        if (runHold == 0) begin
            runCur  = ~runCur;
            runHold = $urandom_range(1, 12);
        end
        runHold--;
        if (forceFreeRun) swCur[15] = 1'b1;
        applyStimulus(1'b0, swCur, runCur);
    endtask

    initial begin
        $display("[TB] ppu_pattern_gen randomized run starting");
        repeat (3) applyStimulus(1'b1, 16'h0000, 1'b0);

        for (int i = 0; i < 1500; i++) begin
            if ((i % 500) == 499) begin
                repeat ($urandom_range(1, 3)) applyStimulus(1'b1, swCur, runCur);
            end else begin
                randomStep(1'b0);
            end
        end

        repeat (2) applyStimulus(1'b1, 16'h0000, 1'b0);
        for (int i = 0; i < DOTS * LINES + 300; i++) begin
            randomStep(i >= 2000);
        end

        @(posedge ppu_clk);
        #2;
        checks++;
        if (expQ.size() == 0) begin
            passes++;
        end else begin
            $display("[TB] FAIL drain: got %0d pending entries, want 0", expQ.size());
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
